red_iterativa_conductual_iad: RTL and testbench

Sequential left-to-right (MSB→LSB) iterative magnitude comparator for two unsigned N-bit words. It resolves one bit position per clock, propagating a three-valued "relation so far" state from the most significant cell toward the least significant one. It asserts `Z_out` when A > B. It is the behavioural reference implementation of the IaD iterative network and sits as a leaf block under the comparator test harness.

---
 rtl/red_iterativa_pkg.sv | 22 ++
 rtl/iad_cell.sv | 26 ++
 rtl/red_iterativa_conductual_iad.sv | 83 ++++++++
 tb/tb_red_iterativa_conductual_iad.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_iterativa_pkg.sv
// rtl/red_iterativa_pkg.sv - shared types and constants for the IaD iterative comparator
package red_iterativa_pkg;

    localparam int RED_N_DEFAULT = 32;

    typedef enum logic [1:0] {
        EQ = 2'b00,
        GT = 2'b01,
        LT = 2'b10
    } rel_t;

    // The unused encoding 2'b11 is folded back onto EQ so a corrupted state
    // restarts the decision instead of latching an undefined relation.
    function automatic rel_t rel_sanitize(input logic [1:0] r);
        case (r)
            2'b01:   return GT;
            2'b10:   return LT;
            default: return EQ;
        endcase
    endfunction

endpackage

// File: rtl/iad_cell.sv
// rtl/iad_cell.sv - one bit cell of the MSB-first magnitude comparison network
module iad_cell
    import red_iterativa_pkg::*;
(
    input  rel_t rel_in,
    input  logic a,
    input  logic b,
    output rel_t rel_out
);

    rel_t rel_clean;

    // GT and LT are absorbing; only an undecided (EQ) relation looks at the bits.
    always_comb begin
        rel_clean = rel_sanitize(rel_in);
        rel_out   = rel_clean;
        if (rel_clean == EQ) begin
            if (a && !b) begin
                rel_out = GT;
            end else if (!a && b) begin
                rel_out = LT;
            end
        end
    end

endmodule

// File: rtl/red_iterativa_conductual_iad.sv
// rtl/red_iterativa_conductual_iad.sv - sequential MSB-first comparator, Z_out = (A > B)
module red_iterativa_conductual_iad
    import red_iterativa_pkg::*;
#(
    parameter int N = RED_N_DEFAULT
)
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         Z_out
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic [CW-1:0]   cnt;
    rel_t            rel;
    rel_t            rel_next;

    iad_cell u_cell (
        .rel_in  (rel),
        .a       (a_reg[cnt]),
        .b       (b_reg[cnt]),
        .rel_out (rel_next)
    );

    // Control FSM: latch operands on an idle start, then walk one bit per
    // clock from N-1 down to 0; the index-0 step publishes the result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
            rel   <= EQ;
            busy  <= 1'b0;
            done  <= 1'b0;
            Z_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= A;
                        b_reg <= B;
                        cnt   <= CW'(N - 1);
                        rel   <= EQ;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    rel <= rel_next;
                    if (cnt == '0) begin
                        Z_out <= (rel_next == GT);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_red_iterativa_conductual_iad.sv
// tb/tb_red_iterativa_conductual_iad.sv - directed self-checking bench for the iterative comparator
module tb_red_iterativa_conductual_iad;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        Z_out;

    logic        start4;
    logic [3:0]  A4;
    logic [3:0]  B4;
    logic        busy4;
    logic        done4;
    logic        Z_out4;

    int vecs;
    int errs;

    red_iterativa_conductual_iad #(.N(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Z_out   (Z_out)
    );

    red_iterativa_conductual_iad #(.N(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start4),
        .A       (A4),
        .B       (B4),
        .busy    (busy4),
        .done    (done4),
        .Z_out   (Z_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one comparison on the 32-bit instance; lat counts edges after
    // the accepting edge up to and including the one that raised done.
    task automatic do_cmp(input logic [31:0] a, input logic [31:0] b,
                          output logic z, output int lat);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        z = Z_out;
    endtask

    task automatic do_cmp4(input logic [3:0] a, input logic [3:0] b,
                           output logic z, output int lat);
        @(negedge clk);
        A4 = a; B4 = b; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        while (done4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        z = Z_out4;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; A = '0; B = '0;
        start4 = 1'b0; A4 = '0; B4 = '0;
        #12;
        vecs++;
        if ({busy, done, Z_out} !== 3'b000) begin
            errs++; $display("FAIL reset32 got %b expected 000", {busy, done, Z_out});
        end
        vecs++;
        if ({busy4, done4, Z_out4} !== 3'b000) begin
            errs++; $display("FAIL reset4 got %b expected 000", {busy4, done4, Z_out4});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic z;
        int   lat;
        @(negedge clk);
        A = 32'h8000_0000; B = 32'h7FFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vecs++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errs++; $display("FAIL accept busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vecs++;
        if (lat !== 32) begin
            errs++; $display("FAIL latency got %0d expected 32", lat);
        end
        vecs++;
        if (Z_out !== 1'b1 || busy !== 1'b0) begin
            errs++; $display("FAIL msb_result Z=%b busy=%b expected Z=1 busy=0", Z_out, busy);
        end
        @(posedge clk); #1;
        vecs++;
        if (done !== 1'b0) begin
            errs++; $display("FAIL done_width got %b expected 0", done);
        end
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if (Z_out !== 1'b1) begin
            errs++; $display("FAIL z_hold got %b expected 1", Z_out);
        end
        do_cmp(32'h0000_0001, 32'h0000_0000, z, lat);
        vecs++;
        if (z !== 1'b1 || lat !== 32) begin
            errs++; $display("FAIL lsb_gt Z=%b lat=%0d expected Z=1 lat=32", z, lat);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic        te [4];
        logic        z;
        int          lat;
        ta[0] = 32'hDEAD_BEEF; tb[0] = 32'hDEAD_BEEF; te[0] = 1'b0;
        ta[1] = 32'h0000_0000; tb[1] = 32'h0000_0001; te[1] = 1'b0;
        ta[2] = 32'hFFFF_FFFF; tb[2] = 32'hFFFF_FFFE; te[2] = 1'b1;
        ta[3] = 32'h7FFF_FFFF; tb[3] = 32'h8000_0000; te[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_cmp(ta[i], tb[i], z, lat);
            vecs++;
            if (z !== te[i] || lat !== 32) begin
                errs++;
                $display("FAIL vector%0d A=%h B=%h Z=%b lat=%0d expected Z=%b lat=32",
                         i, ta[i], tb[i], z, lat, te[i]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int ndone;
        @(negedge clk);
        A = 32'd5; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (c >= 3 && c < 10) begin
                A = 32'd0; B = 32'hFFFF_FFFF; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        vecs++;
        if (ndone !== 1) begin
            errs++; $display("FAIL ignore_done_count got %0d expected 1", ndone);
        end
        vecs++;
        if (Z_out !== 1'b1 || busy !== 1'b0) begin
            errs++; $display("FAIL ignore_result Z=%b busy=%b expected Z=1 busy=0", Z_out, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic z;
        int   lat;
        int   ndone;
        @(negedge clk);
        A = 32'hF000_0000; B = 32'h0F00_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        vecs++;
        if ({busy, done, Z_out} !== 3'b000) begin
            errs++; $display("FAIL reset_mid got %b expected 000", {busy, done, Z_out});
        end
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        vecs++;
        if (ndone !== 0) begin
            errs++; $display("FAIL reset_mid_quiet got %0d active cycles expected 0", ndone);
        end
        do_cmp(32'h0000_0001, 32'h0000_0000, z, lat);
        vecs++;
        if (z !== 1'b1 || lat !== 32) begin
            errs++; $display("FAIL after_reset Z=%b lat=%0d expected Z=1 lat=32", z, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        A = 32'd10; B = 32'd20; start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vecs++;
        if (lat !== 32 || Z_out !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL b2b_first lat=%0d Z=%b busy=%b expected 32 0 0", lat, Z_out, busy);
        end
        @(negedge clk);
        A = 32'd20; B = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        vecs++;
        if (busy !== 1'b1) begin
            errs++; $display("FAIL b2b_accept busy=%b expected 1", busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vecs++;
        if (lat !== 32 || Z_out !== 1'b1) begin
            errs++; $display("FAIL b2b_second lat=%0d Z=%b expected 32 1", lat, Z_out);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] rb;
        logic        z;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? ra : $urandom;
            do_cmp(ra, rb, z, lat);
            vecs++;
            if (z !== (ra > rb) || lat !== 32) begin
                errs++;
                $display("FAIL random%0d A=%h B=%h Z=%b lat=%0d expected Z=%b lat=32",
                         i, ra, rb, z, lat, (ra > rb));
            end
        end
    endtask

    task automatic test_exhaustive_n4();
        logic z;
        int   lat;
        int   bad;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_cmp4(4'(a), 4'(b), z, lat);
                vecs++;
                if (z !== (a > b) || lat !== 4) begin
                    errs++;
                    $display("FAIL n4 A=%0d B=%0d Z=%b lat=%0d expected Z=%b lat=4",
                             a, b, z, lat, (a > b));
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_exhaustive_n4();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
